// File: rtl/stage_execute_muldiv_pkg.sv
// Shared MD-unit constants: op encodings, default latencies, pending-result payload.
// Optional multiply-accumulate group enabled by MDU_MADD_EN.
package stage_execute_muldiv_pkg;

   localparam int unsigned MD_OP_LEN       = 4;
   localparam int unsigned XLEN            = 32;
   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;
   localparam int unsigned CNT_W_DEF       = 4;

   typedef enum logic [MD_OP_LEN-1:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MFHI  = 4'd7,
      MD_MFLO  = 4'd8
`ifdef MDU_MADD_EN
      ,
      MD_MADD  = 4'd9,
      MD_MADDU = 4'd10,
      MD_MSUB  = 4'd11,
      MD_MSUBU = 4'd12
`endif
   } md_op_e;

   typedef struct packed {
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
      logic            div_by_zero;
   } md_pend_t;

   // Ops that occupy the counter when started.
   function automatic logic is_launch(input logic [MD_OP_LEN-1:0] op);
      logic r;
      r = 1'b0;
      case (op)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
         MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_div(input logic [MD_OP_LEN-1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

`ifdef MDU_MADD_EN
   function automatic logic is_acc(input logic [MD_OP_LEN-1:0] op);
      return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
   endfunction

   function automatic logic is_sub(input logic [MD_OP_LEN-1:0] op);
      return (op == MD_MSUB) || (op == MD_MSUBU);
   endfunction
`endif

endpackage

// File: rtl/stage_execute_muldiv_md_compute.sv
// Combinational product / quotient-remainder for the MD unit.
// Optional multiply-accumulate encodings enabled by MDU_MADD_EN.
module stage_execute_muldiv_md_compute
   import stage_execute_muldiv_pkg::*;
(
   input  logic [MD_OP_LEN-1:0] md_op,
   input  logic [XLEN-1:0]      grf_in0,
   input  logic [XLEN-1:0]      grf_in1,
   output md_pend_t             res
);

   logic [2*XLEN-1:0] prod_s;
   logic [2*XLEN-1:0] prod_u;
   logic              dbz;
   logic              sgn;
   logic [XLEN-1:0]   dvs_safe;
   logic [XLEN-1:0]   dvd;
   logic [XLEN-1:0]   dvs;
   logic [XLEN-1:0]   q_raw;
   logic [XLEN-1:0]   r_raw;
   logic [XLEN-1:0]   q_fix;
   logic [XLEN-1:0]   r_fix;

   // One unsigned divider serves both forms; signed runs on magnitudes and fixes signs after,
   // which also makes 0x80000000 / -1 fall out as 0x80000000 rem 0 without overflow.
   always_comb begin
      prod_s   = {{XLEN{grf_in0[XLEN-1]}}, grf_in0} * {{XLEN{grf_in1[XLEN-1]}}, grf_in1};
      prod_u   = {{XLEN{1'b0}}, grf_in0} * {{XLEN{1'b0}}, grf_in1};
      dbz      = (grf_in1 == '0);
      sgn      = (md_op == MD_DIV);
      dvs_safe = dbz ? XLEN'(1) : grf_in1;
      dvd      = (sgn && grf_in0[XLEN-1])  ? -grf_in0  : grf_in0;
      dvs      = (sgn && dvs_safe[XLEN-1]) ? -dvs_safe : dvs_safe;
      q_raw    = dvd / dvs;
      r_raw    = dvd % dvs;
      q_fix    = (sgn && (grf_in0[XLEN-1] ^ dvs_safe[XLEN-1])) ? -q_raw : q_raw;
      r_fix    = (sgn && grf_in0[XLEN-1]) ? -r_raw : r_raw;

      res = '0;
      case (md_op)
         MD_MULT:  {res.hi, res.lo} = prod_s;
         MD_MULTU: {res.hi, res.lo} = prod_u;
`ifdef MDU_MADD_EN
         MD_MADD, MD_MSUB:   {res.hi, res.lo} = prod_s;
         MD_MADDU, MD_MSUBU: {res.hi, res.lo} = prod_u;
`endif
         MD_DIV, MD_DIVU: begin
            res.hi          = r_fix;
            res.lo          = q_fix;
            res.div_by_zero = dbz;
         end
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/stage_execute_muldiv.sv
// Execute-stage multiply/divide unit: fixed-latency countdown, HI/LO ownership, MT/MF access.
// Optional MADD/MADDU/MSUB/MSUBU accumulate enabled by MDU_MADD_EN.
module stage_execute_muldiv
   import stage_execute_muldiv_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [MD_OP_LEN-1:0] md_op,
   input  logic                 start,
   input  logic [XLEN-1:0]      grf_in0,
   input  logic [XLEN-1:0]      grf_in1,
   input  logic                 cancel,
   output logic                 busy,
   output logic [XLEN-1:0]      hi,
   output logic [XLEN-1:0]      lo,
   output logic [XLEN-1:0]      md_result
);

   logic [CNT_W-1:0]  cnt;
   md_pend_t          pend;
   md_pend_t          comp;
   logic [2*XLEN-1:0] wb_val;
`ifdef MDU_MADD_EN
   logic              pend_acc;
   logic              pend_sub;
`endif

   stage_execute_muldiv_md_compute u_md_compute (
      .md_op   (md_op),
      .grf_in0 (grf_in0),
      .grf_in1 (grf_in1),
      .res     (comp)
   );

   assign busy      = (cnt != '0);
   assign md_result = (md_op == MD_MFHI) ? hi :
                      (md_op == MD_MFLO) ? lo : '0;

   // Value written to {hi,lo} on the completing edge; accumulate reads live hi/lo.
   always_comb begin
      wb_val = {pend.hi, pend.lo};
`ifdef MDU_MADD_EN
      if (pend_acc) begin
         wb_val = pend_sub ? ({hi, lo} - {pend.hi, pend.lo})
                           : ({hi, lo} + {pend.hi, pend.lo});
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         hi   <= '0;
         lo   <= '0;
         pend <= '0;
`ifdef MDU_MADD_EN
         pend_acc <= 1'b0;
         pend_sub <= 1'b0;
`endif
      end else if (cancel) begin
         cnt  <= '0;
         pend <= '0;
      end else if (busy) begin
         cnt <= cnt - CNT_W'(1);
         if ((cnt == CNT_W'(1)) && !pend.div_by_zero) begin
            hi <= wb_val[2*XLEN-1:XLEN];
            lo <= wb_val[XLEN-1:0];
         end
      end else if (start && is_launch(md_op)) begin
         pend <= comp;
         cnt  <= is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
`ifdef MDU_MADD_EN
         pend_acc <= is_acc(md_op);
         pend_sub <= is_sub(md_op);
`endif
      end else if (md_op == MD_MTHI) begin
         hi <= grf_in0;
      end else if (md_op == MD_MTLO) begin
         lo <= grf_in0;
      end
   end

endmodule

// File: tb/tb_stage_execute_muldiv.sv
// Directed scoreboard bench for stage_execute_muldiv; MADD case runs when MDU_MADD_EN is defined.
module tb_stage_execute_muldiv;
   import stage_execute_muldiv_pkg::*;

   logic                 clk;
   logic                 reset_n;
   logic [MD_OP_LEN-1:0] md_op;
   logic                 start;
   logic [31:0]          grf_in0;
   logic [31:0]          grf_in1;
   logic                 cancel;
   logic                 busy;
   logic [31:0]          hi;
   logic [31:0]          lo;
   logic [31:0]          md_result;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [63:0] sb[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   stage_execute_muldiv dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .md_op     (md_op),
      .start     (start),
      .grf_in0   (grf_in0),
      .grf_in1   (grf_in1),
      .cancel    (cancel),
      .busy      (busy),
      .hi        (hi),
      .lo        (lo),
      .md_result (md_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // mode 0: plain run, 1: ignored start+MTLO while busy, 2: cancel at cycle 3
   task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] eh, input logic [31:0] el,
                         input int mode, input string name);
      logic [63:0] exp;
      if (mode == 2) sb.push_back({m_hi, m_lo});
      else           sb.push_back({eh, el});
      @(negedge clk);
      md_op = op; start = 1'b1; grf_in0 = a; grf_in1 = b;
      @(negedge clk);
      start = 1'b0; md_op = MD_NONE;
      for (int i = 1; i <= lat; i++) begin
         check($sformatf("%s_busy%0d", name, i), 64'(busy), 64'd1);
         if (mode == 1 && i == 2) begin
            md_op = MD_MULTU; start = 1'b1; grf_in0 = 32'h0000_1234; grf_in1 = 32'h10;
         end
         if (mode == 1 && i == 3) begin
            md_op = MD_MTLO; grf_in0 = 32'hDEAD_BEEF;
         end
         if (mode == 2 && i == 3) cancel = 1'b1;
         @(negedge clk);
         start = 1'b0; md_op = MD_NONE;
         if (cancel) begin
            cancel = 1'b0;
            break;
         end
      end
      check({name, "_busy_low"}, 64'(busy), 64'd0);
      exp = sb.pop_front();
      md_op = MD_MFLO; #1;
      check({name, "_hi"}, 64'(hi), 64'(exp[63:32]));
      check({name, "_lo"}, 64'(lo), 64'(exp[31:0]));
      check({name, "_mflo"}, 64'(md_result), 64'(exp[31:0]));
      md_op = MD_MFHI; #1;
      check({name, "_mfhi"}, 64'(md_result), 64'(exp[63:32]));
      md_op = MD_NONE;
      if (mode == 1) begin
         @(negedge clk);
         check({name, "_no_restart"}, 64'(busy), 64'd0);
         check({name, "_lo_kept"}, 64'(lo), 64'(exp[31:0]));
      end
      m_hi = exp[63:32];
      m_lo = exp[31:0];
   endtask

   task automatic mt(input md_op_e op, input logic [31:0] v);
      @(negedge clk);
      md_op = op; grf_in0 = v;
      @(negedge clk);
      md_op = MD_NONE;
      if (op == MD_MTHI) begin
         m_hi = v;
         check("mthi", 64'(hi), 64'(v));
      end else begin
         m_lo = v;
         check("mtlo", 64'(lo), 64'(v));
      end
   endtask

   initial begin
      reset_n = 1'b0; md_op = MD_NONE; start = 1'b0; cancel = 1'b0;
      grf_in0 = '0; grf_in1 = '0;
      #12;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_none", 64'(md_result), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, "mult");
      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001, 0, "multu");
      run_op(MD_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD, 0, "div");
      run_op(MD_DIVU,  32'hFFFF_FFFF, 32'h10,        10, 32'hF,         32'h0FFF_FFFF, 0, "divu");
      run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000, 0, "div_ovf");

      mt(MD_MTHI, 32'h11);
      mt(MD_MTLO, 32'h22);
      run_op(MD_DIV,   32'd5,         32'd0,         10, 32'h11,        32'h22,        0, "div0");

      run_op(MD_DIV,   32'd100,       32'd7,         10, 32'd2,         32'd14,        1, "ignored");
      run_op(MD_MULT,  32'd1000,      32'd1000,      5,  32'd0,         32'd0,         2, "cancel");

      // asynchronous reset while a DIV is in flight
      @(negedge clk);
      md_op = MD_DIV; start = 1'b1; grf_in0 = 32'd9; grf_in1 = 32'd2;
      @(negedge clk);
      start = 1'b0; md_op = MD_NONE;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_hi", 64'(hi), 64'd0);
      check("arst_lo", 64'(lo), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      m_hi = '0; m_lo = '0;
      repeat (11) @(negedge clk);
      check("arst_no_resume", {hi, lo}, 64'd0);

`ifdef MDU_MADD_EN
      mt(MD_MTHI, 32'd0);
      mt(MD_MTLO, 32'hFFFF_FFFF);
      run_op(MD_MADDU, 32'd1, 32'd1, 5, 32'd1, 32'd0, 0, "maddu");
      run_op(MD_MSUB,  32'd2, 32'hFFFF_FFFF, 5, 32'd1, 32'd2, 0, "msub");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/stage_execute_muldiv.md
Name: stage_execute_muldiv

Overview:
- Multiply/divide unit beside the execute-stage ALU. It consumes the same forwarded operands (grf_in0 = rs, grf_in1 = rt).
- Implements MULT/MULTU/DIV/DIVU with fixed multi-cycle latency. Owns the HI/LO architectural registers and serves MFHI/MFLO/MTHI/MTLO.
- The decode stage stalls any MD-class instruction while start or busy is high.

Parameters:
- MULT_CYCLES, 5, busy cycles after an accepted MULT/MULTU start.
- DIV_CYCLES, 10, busy cycles after an accepted DIV/DIVU start.
- CNT_W, 4, down-counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- md_op  input  `MD_OP_LEN  operation select: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- start  input  1  one-cycle pulse that launches the MULT/MULTU/DIV/DIVU selected by md_op.
- grf_in0  input  32  rs operand, already forwarded.
- grf_in1  input  32  rt operand; the divisor for DIV/DIVU.
- cancel  input  1  abort the in-flight operation (later-stage exception).
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.
- md_result  output  32  md_op==MFHI ? hi : md_op==MFLO ? lo : 0; combinational.

Behaviour:
- Reset: asynchronous on reset_n low. hi=0, lo=0, cnt=0, busy=0, pending registers=0. Reset during an operation discards it.
- busy = (cnt != 0), driven straight from the counter, no extra flop.
- Accept: on a rising edge with start=1, busy=0, cancel=0 and md_op in {MULT, MULTU, DIV, DIVU}:
  - compute the result from grf_in0/grf_in1 and latch it into pend_hi/pend_lo;
  - load cnt with MULT_CYCLES or DIV_CYCLES.
- start while busy=1: ignored; the in-flight op is unaffected. Decode must prevent this; the bench checks it is harmless.
- Countdown: each edge with cnt>0 and cancel=0 decrements cnt. On the edge where cnt goes 1→0, hi<=pend_hi and lo<=pend_lo.
- Timing: start sampled at edge T. busy is high from T through T+N. New hi/lo are visible after edge T+N, the same cycle busy falls.
- MULT: {hi,lo} = signed 32×32 → 64-bit product. MULTU: unsigned product.
- DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, no trap.
- DIVU: unsigned quotient and remainder.
- Divide by zero (grf_in1==0): op is accepted and busy runs the full DIV_CYCLES, but hi/lo stay unchanged at completion.
- MTHI/MTLO: with busy=0 and cancel=0, hi<=grf_in0 or lo<=grf_in0 at the edge; start is not required. Ignored while busy.
- cancel=1: forces cnt<=0 at the edge and drops the pending result; hi/lo untouched. A same-cycle start or MTHI/MTLO is also ignored.
- md_result reflects current hi/lo. MFHI in the cycle busy falls returns the new value.
- md_op==NONE: no state change.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: md_op also encodes MADD, MADDU, MSUB, MSUBU. These use MULT_CYCLES latency; at completion {hi,lo} <= {hi,lo} ± product (signed or unsigned), wrapping mod 2^64. The accumulator uses {hi,lo} as sampled at completion.
- Undefined: those encodings are absent from the package. Any unlisted md_op with start=1 is treated as NONE.

Decomposition:
- def.v (shared constants header):
  - `MD_OP_LEN and all `MD_OP_* encodings, including the MADD group under the macro;
  - default latency constants, shared with the decode stall logic.
- Sub-module: md_compute, purely combinational. Maps md_op, grf_in0 and grf_in1 to {pend_hi, pend_lo, div_by_zero}.
- Counter, handshake and HI/LO registers stay in stage_execute_muldiv.

Test Plan:
- Signed MULT: grf_in0=0xFFFFFFFE (-2), grf_in1=3, start pulse → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV: 7 / -2 → after 10 cycles lo=0xFFFFFFFD, hi=1. DIVU 0xFFFFFFFF/0x10 → lo=0x0FFFFFFF, hi=0xF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: hi=0x11, lo=0x22 preset via MTHI/MTLO; DIV x/0 → busy 10 cycles; hi=0x11, lo=0x22 afterwards.
- Ignored requests: start of MULTU while busy with a DIV, plus MTLO while busy → both ignored; DIV result lands at the original cycle; lo is not overwritten by the MTLO value.
- Cancel: cancel asserted at cycle 3 of a MULT → busy drops next edge; hi/lo keep the pre-op values. reset_n low mid-DIV → hi=lo=0 and busy=0 immediately, asynchronously.
- MFHI/MFLO: md_op=MFLO in the cycle busy falls → md_result equals the new lo. With MDU_MADD_EN: hi:lo=0:0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0.
